// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the fully connected backward-pass engine.
//   WEIGHT_WIDTH / ACC_WIDTH : default data and accumulator widths
//   fc_bwd_state_t           : engine FSM states
//   sat_trunc()              : accumulator -> output conversion
// Optional feature macro: FC_BWD_SATURATE_EN
//   defined   -> shifted accumulator is clamped to the signed output range
//   undefined -> low WEIGHT_WIDTH bits are kept (two's-complement wrap)
// ---------------------------------------------------------------------------
package fc_pkg;

  localparam int WEIGHT_WIDTH = 16;
  localparam int ACC_WIDTH    = 40;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    FLUSH,
    OUT
  } fc_bwd_state_t;

`ifdef FC_BWD_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WEIGHT_WIDTH-1)) - 1);
  // Bitwise inverse of 0..0111..1 is 1..1000..0, the most negative output value.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

  // Arithmetic shift rounds toward -inf; range handling depends on the build.
  function automatic logic signed [WEIGHT_WIDTH-1:0] sat_trunc(
    input logic signed [ACC_WIDTH-1:0] acc,
    input int unsigned                 frac
  );
    logic signed [ACC_WIDTH-1:0] shifted;
    shifted = acc >>> frac;
`ifdef FC_BWD_SATURATE_EN
    if (shifted > SAT_MAX) begin
      shifted = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      shifted = SAT_MIN;
    end
`endif
    return shifted[WEIGHT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// ---------------------------------------------------------------------------
// fc_mac_unit
// Signed multiply-accumulate with a registered accumulator.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the accumulator on the next edge (wins over en)
//   en       : add a*b on the next edge
//   a, b     : signed operands
//   sum      : accumulator plus the current product when en is high, i.e. the
//              value the accumulator takes on the next edge
// ---------------------------------------------------------------------------
module fc_mac_unit #(
  parameter int WEIGHT_WIDTH = fc_pkg::WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = fc_pkg::ACC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           en,
  input  logic signed [WEIGHT_WIDTH-1:0] a,
  input  logic signed [WEIGHT_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]    sum
);

  logic signed [ACC_WIDTH-1:0]      acc;
  logic signed [2*WEIGHT_WIDTH-1:0] product;

  // Full-precision product, sign-extended into the accumulator width.
  always_comb begin
    product = a * b;
    sum     = acc;
    if (en) begin
      sum = acc + {{(ACC_WIDTH-2*WEIGHT_WIDTH){product[2*WEIGHT_WIDTH-1]}}, product};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fc_backprop_engine.sv
// ---------------------------------------------------------------------------
// fc_backprop_engine
// Backward pass of a fully connected layer: dX[j] = sum_i W[j][i] * dY[i].
//   clk, rst           : clock, synchronous active-high reset
//   dy_valid/ready/data: incoming dY stream, OUTPUT_SIZE beats in order
//   w_rd_en/addr/data  : shared weight memory port, data one cycle after en,
//                        address j*OUTPUT_SIZE + i
//   dx_valid/ready/data: outgoing dX stream, INPUT_SIZE results
//   dx_last            : marks dX[INPUT_SIZE-1]
//   busy               : engine is not idle
//   done               : one-cycle pulse after the final dX handshake
// Optional feature macro: FC_BWD_SATURATE_EN (see fc_pkg::sat_trunc).
// ---------------------------------------------------------------------------
module fc_backprop_engine #(
  parameter  int INPUT_SIZE   = 784,
  parameter  int OUTPUT_SIZE  = 128,
  parameter  int WEIGHT_WIDTH = fc_pkg::WEIGHT_WIDTH,
  parameter  int ACC_WIDTH    = fc_pkg::ACC_WIDTH,
  parameter  int FRAC_BITS    = 8,
  localparam int ADDR_WIDTH   = $clog2(INPUT_SIZE*OUTPUT_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dy_valid,
  output logic                           dy_ready,
  input  logic signed [WEIGHT_WIDTH-1:0] dy_data,
  output logic                           w_rd_en,
  output logic        [ADDR_WIDTH-1:0]   w_rd_addr,
  input  logic signed [WEIGHT_WIDTH-1:0] w_rd_data,
  output logic                           dx_valid,
  input  logic                           dx_ready,
  output logic signed [WEIGHT_WIDTH-1:0] dx_data,
  output logic                           dx_last,
  output logic                           busy,
  output logic                           done
);

  import fc_pkg::*;

  localparam int IW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int JW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(OUTPUT_SIZE-1);
  localparam logic [JW-1:0] J_LAST = JW'(INPUT_SIZE-1);

  fc_bwd_state_t                  state;
  logic        [IW-1:0]           i;
  logic        [JW-1:0]           j;
  logic        [IW-1:0]           rd_idx;
  logic                           rd_pend;
  logic                           beat;
  logic                           mac_clear;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic signed [WEIGHT_WIDTH-1:0] dy_buf [OUTPUT_SIZE];

  assign beat = dy_valid && dy_ready;

  // The accumulator is held at zero while loading and cleared as a result is
  // accepted, so every COMPUTE pass starts from zero.
  assign mac_clear = (state == IDLE) || (state == LOAD) || ((state == OUT) && dx_ready);

  // i is zero in IDLE, so the first beat lands in dy_buf[0].
  always_ff @(posedge clk) begin
    if (beat) begin
      dy_buf[i] <= dy_data;
    end
  end

  // rd_pend/rd_idx trail the read strobe by one cycle so the returning weight
  // is paired with the dY element whose address was issued.
  fc_mac_unit #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .en    (rd_pend),
    .a     (w_rd_data),
    .b     (dy_buf[rd_idx]),
    .sum   (acc_sum)
  );

  // Main FSM with registered outputs. Addresses of consecutive j are
  // contiguous, so w_rd_addr simply increments across the whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      rd_idx    <= '0;
      rd_pend   <= 1'b0;
      dy_ready  <= 1'b1;
      w_rd_en   <= 1'b0;
      w_rd_addr <= '0;
      dx_valid  <= 1'b0;
      dx_data   <= '0;
      dx_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= w_rd_en;
      rd_idx  <= i;
      case (state)
        IDLE, LOAD: begin
          if (beat) begin
            busy <= 1'b1;
            if (i == I_LAST) begin
              state     <= COMPUTE;
              i         <= '0;
              j         <= '0;
              dy_ready  <= 1'b0;
              w_rd_en   <= 1'b1;
              w_rd_addr <= '0;
            end else begin
              state <= LOAD;
              i     <= i + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (i == I_LAST) begin
            state   <= FLUSH;
            w_rd_en <= 1'b0;
          end else begin
            i         <= i + 1'b1;
            w_rd_addr <= w_rd_addr + 1'b1;
          end
        end
        // acc_sum already includes the final product arriving this cycle.
        FLUSH: begin
          state    <= OUT;
          dx_valid <= 1'b1;
          dx_data  <= sat_trunc(acc_sum, FRAC_BITS);
          dx_last  <= (j == J_LAST);
        end
        OUT: begin
          if (dx_ready) begin
            dx_valid <= 1'b0;
            dx_last  <= 1'b0;
            i        <= '0;
            if (j == J_LAST) begin
              state    <= IDLE;
              j        <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              dy_ready <= 1'b1;
            end else begin
              state     <= COMPUTE;
              j         <= j + 1'b1;
              w_rd_en   <= 1'b1;
              w_rd_addr <= w_rd_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_backprop_engine.sv
// ---------------------------------------------------------------------------
// tb_fc_backprop_engine
// Directed bench for fc_backprop_engine with a 4x3 layer. Two instances:
//   dut0 with FRAC_BITS=0, dut1 with FRAC_BITS=8. Each has its own weight
//   memory model. Stimulus pushes hand-computed results into a queue; a
//   monitor pops and compares on every dX handshake, and also tracks the
//   address sequence, result latency, dy_ready backpressure and done pulse.
// ---------------------------------------------------------------------------
module tb_fc_backprop_engine;

  localparam int IN_SZ  = 4;
  localparam int OUT_SZ = 3;
  localparam int WW     = 16;
  localparam int AW     = $clog2(IN_SZ*OUT_SZ);
  localparam int NW     = IN_SZ*OUT_SZ;

`ifdef FC_BWD_SATURATE_EN
  localparam logic [WW-1:0] BIG_EXP = 16'h7FFF;
`else
  localparam logic [WW-1:0] BIG_EXP = 16'h0003;
`endif

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dy_valid  [2];
  logic          dy_ready  [2];
  logic [WW-1:0] dy_data   [2];
  logic          w_rd_en   [2];
  logic [AW-1:0] w_rd_addr [2];
  logic [WW-1:0] w_rd_data [2];
  logic          dx_valid  [2];
  logic          dx_ready  [2];
  logic [WW-1:0] dx_data   [2];
  logic          dx_last   [2];
  logic          busy      [2];
  logic          done      [2];

  logic [WW-1:0] mem0 [NW];
  logic [WW-1:0] mem1 [NW];

  exp_t q0[$];
  exp_t q1[$];

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            hs_cnt    [2] = '{0, 0};
  int            done_cnt  [2] = '{0, 0};
  int            exp_addr  [2] = '{0, 0};
  int            lat_start [2] = '{0, 0};
  logic          prev_en   [2] = '{1'b0, 1'b0};
  logic          prev_val  [2] = '{1'b0, 1'b0};
  logic          done_pend [2] = '{1'b0, 1'b0};
  logic          bp_active = 1'b0;
  logic [WW-1:0] bp_val = '0;

  always #5 clk = ~clk;

  fc_backprop_engine #(
    .INPUT_SIZE(IN_SZ), .OUTPUT_SIZE(OUT_SZ), .WEIGHT_WIDTH(WW), .ACC_WIDTH(40), .FRAC_BITS(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .dy_valid(dy_valid[0]), .dy_ready(dy_ready[0]), .dy_data(dy_data[0]),
    .w_rd_en(w_rd_en[0]), .w_rd_addr(w_rd_addr[0]), .w_rd_data(w_rd_data[0]),
    .dx_valid(dx_valid[0]), .dx_ready(dx_ready[0]), .dx_data(dx_data[0]),
    .dx_last(dx_last[0]), .busy(busy[0]), .done(done[0])
  );

  fc_backprop_engine #(
    .INPUT_SIZE(IN_SZ), .OUTPUT_SIZE(OUT_SZ), .WEIGHT_WIDTH(WW), .ACC_WIDTH(40), .FRAC_BITS(8)
  ) dut1 (
    .clk(clk), .rst(rst),
    .dy_valid(dy_valid[1]), .dy_ready(dy_ready[1]), .dy_data(dy_data[1]),
    .w_rd_en(w_rd_en[1]), .w_rd_addr(w_rd_addr[1]), .w_rd_data(w_rd_data[1]),
    .dx_valid(dx_valid[1]), .dx_ready(dx_ready[1]), .dx_data(dx_data[1]),
    .dx_last(dx_last[1]), .busy(busy[1]), .done(done[1])
  );

  // Weight memories: one-cycle read latency, junk when not read.
  always @(posedge clk) begin
    w_rd_data[0] <= w_rd_en[0] ? mem0[w_rd_addr[0]] : 16'hDEAD;
    w_rd_data[1] <= w_rd_en[1] ? mem1[w_rd_addr[1]] : 16'hDEAD;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: scoreboard pops on handshakes plus per-cycle protocol checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (!busy[d]) exp_addr[d] = 0;
        if (w_rd_en[d]) begin
          checkOutput($sformatf("w_rd_addr dut%0d", d), 64'(w_rd_addr[d]), 64'(exp_addr[d]));
          exp_addr[d]++;
          if (!prev_en[d]) lat_start[d] = cyc;
        end
        if (dx_valid[d] && !prev_val[d])
          checkOutput($sformatf("latency dut%0d", d), 64'(cyc - lat_start[d]), 64'd4);
        if (w_rd_en[d] || dx_valid[d])
          checkOutput($sformatf("dy_ready_low dut%0d", d), 64'(dy_ready[d]), 64'd0);
        if (done_pend[d]) begin
          checkOutput($sformatf("done_pulse dut%0d", d), 64'(done[d]), 64'd1);
          done_pend[d] = 1'b0;
        end else begin
          checkOutput($sformatf("done_quiet dut%0d", d), 64'(done[d]), 64'd0);
        end
        if (done[d]) done_cnt[d]++;
        if (dx_valid[d] && dx_ready[d]) begin
          hs_cnt[d]++;
          if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_dx dut%0d: got %0h, expected no result", d, dx_data[d]);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput($sformatf("dx_data dut%0d #%0d", d, hs_cnt[d]), 64'(dx_data[d]), 64'(e.data));
            checkOutput($sformatf("dx_last dut%0d #%0d", d, hs_cnt[d]), 64'(dx_last[d]), 64'(e.last));
            if (e.last) done_pend[d] = 1'b1;
          end
        end
        prev_en[d]  = w_rd_en[d];
        prev_val[d] = dx_valid[d];
      end
      if (bp_active) begin
        checkOutput("bp_valid", 64'(dx_valid[0]), 64'd1);
        checkOutput("bp_data", 64'(dx_data[0]), 64'(bp_val));
        checkOutput("bp_rd_en", 64'(w_rd_en[0]), 64'd0);
      end
    end
  end

  task automatic loadWeights(input int d, input logic [WW-1:0] base, input logic [WW-1:0] step);
    for (int k = 0; k < NW; k++) begin
      if (d == 0) mem0[k] = base + step * WW'(k);
      else        mem1[k] = base + step * WW'(k);
    end
  endtask

  task automatic pushResults(input int d, input logic [WW-1:0] r0, input logic [WW-1:0] r1,
                             input logic [WW-1:0] r2, input logic [WW-1:0] r3, input int n);
    logic [WW-1:0] r [4];
    exp_t e;
    r = '{r0, r1, r2, r3};
    for (int k = 0; k < n; k++) begin
      e.data = r[k];
      e.last = (k == IN_SZ-1);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Drive dY beats following a valid pattern (bit k = cycle k), then hold
  // dy_valid high with junk for 'junk' cycles while the engine is busy.
  task automatic applyStimulus(input int d, input logic [WW-1:0] v0, input logic [WW-1:0] v1,
                               input logic [WW-1:0] v2, input logic [7:0] pat, input int len,
                               input int junk);
    logic [WW-1:0] dys [3];
    int b;
    dys = '{v0, v1, v2};
    b = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      dy_valid[d] = pat[k];
      dy_data[d]  = pat[k] ? dys[b] : 16'hBEEF;
      if (pat[k]) b++;
    end
    for (int k = 0; k < junk; k++) begin
      @(negedge clk);
      dy_valid[d] = 1'b1;
      dy_data[d]  = 16'h7777;
    end
    @(negedge clk);
    dy_valid[d] = 1'b0;
  endtask

  task automatic waitDone(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt[d] < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt[d] < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_done dut%0d: done count %0d, expected %0d", d, done_cnt[d], target);
    end
  endtask

  task automatic waitHandshakes(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (hs_cnt[d] < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (hs_cnt[d] < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_hs dut%0d: handshakes %0d, expected %0d", d, hs_cnt[d], target);
    end
  endtask

  task automatic checkReset(input int d);
    checkOutput($sformatf("rst dy_ready dut%0d", d), 64'(dy_ready[d]), 64'd1);
    checkOutput($sformatf("rst w_rd_en dut%0d", d), 64'(w_rd_en[d]), 64'd0);
    checkOutput($sformatf("rst w_rd_addr dut%0d", d), 64'(w_rd_addr[d]), 64'd0);
    checkOutput($sformatf("rst dx_valid dut%0d", d), 64'(dx_valid[d]), 64'd0);
    checkOutput($sformatf("rst dx_data dut%0d", d), 64'(dx_data[d]), 64'd0);
    checkOutput($sformatf("rst dx_last dut%0d", d), 64'(dx_last[d]), 64'd0);
    checkOutput($sformatf("rst busy dut%0d", d), 64'(busy[d]), 64'd0);
    checkOutput($sformatf("rst done dut%0d", d), 64'(done[d]), 64'd0);
  endtask

  task automatic checkQueueEmpty(input int d);
    checkOutput($sformatf("queue_empty dut%0d", d), 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      dy_valid[d] = 1'b0;
      dy_data[d]  = '0;
      dx_ready[d] = 1'b1;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkReset(0);
    checkReset(1);
    rst = 1'b0;

    // All weights 1, dY = {1,2,3}: every dX is 6
    $display("[TB] run: unit weights");
    loadWeights(0, 16'd1, 16'd0);
    pushResults(0, 16'd6, 16'd6, 16'd6, 16'd6, 4);
    applyStimulus(0, 16'd1, 16'd2, 16'd3, 8'b0000_0111, 3, 0);
    waitDone(0, done_cnt[0] + 1, 200);
    checkQueueEmpty(0);

    // Weights 1..12, dY = {1,2,3}: dX[j] = 18j+14, stalled at j=1
    $display("[TB] run: backpressure");
    loadWeights(0, 16'd1, 16'd1);
    pushResults(0, 16'd14, 16'd32, 16'd50, 16'd68, 4);
    applyStimulus(0, 16'd1, 16'd2, 16'd3, 8'b0000_0111, 3, 0);
    waitHandshakes(0, hs_cnt[0] + 1, 200);
    dx_ready[0] = 1'b0;
    n = 0;
    while (!dx_valid[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_wait_valid", 64'(dx_valid[0]), 64'd1);
    bp_val    = 16'd32;
    bp_active = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bp_active   = 1'b0;
    dx_ready[0] = 1'b1;
    waitDone(0, done_cnt[0] + 1, 200);
    checkQueueEmpty(0);

    // Largest positive operands: wraps or saturates depending on the build
    $display("[TB] run: overflow");
    loadWeights(0, 16'h7FFF, 16'd0);
    pushResults(0, BIG_EXP, BIG_EXP, BIG_EXP, BIG_EXP, 4);
    applyStimulus(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 8'b0000_0111, 3, 0);
    waitDone(0, done_cnt[0] + 1, 200);
    checkQueueEmpty(0);

    // FRAC_BITS=8: 0x100*(0x180-0x200+0x40) = -0x4000, >>>8 = 0xFFC0
    $display("[TB] run: fractional shift");
    loadWeights(1, 16'h0100, 16'd0);
    pushResults(1, 16'hFFC0, 16'hFFC0, 16'hFFC0, 16'hFFC0, 4);
    applyStimulus(1, 16'h0180, 16'hFE00, 16'h0040, 8'b0000_0111, 3, 0);
    waitDone(1, done_cnt[1] + 1, 200);
    checkQueueEmpty(1);

    // Gapped dY beats {2,-1,4} with weights 1..12: dX[j] = 15j+12, plus
    // ignored dy_valid while busy
    $display("[TB] run: gapped input");
    loadWeights(0, 16'd1, 16'd1);
    pushResults(0, 16'd12, 16'd27, 16'd42, 16'd57, 4);
    applyStimulus(0, 16'd2, 16'hFFFF, 16'd4, 8'b0010_1001, 6, 3);
    waitDone(0, done_cnt[0] + 1, 200);
    checkQueueEmpty(0);

    // Reset during COMPUTE of j=2, then a fresh run
    $display("[TB] run: mid-run reset");
    loadWeights(0, 16'd1, 16'd0);
    pushResults(0, 16'd6, 16'd6, 16'd6, 16'd6, 2);
    applyStimulus(0, 16'd1, 16'd2, 16'd3, 8'b0000_0111, 3, 0);
    waitHandshakes(0, hs_cnt[0] + 2, 200);
    rst = 1'b1;
    @(posedge clk); #1;
    checkReset(0);
    rst = 1'b0;
    checkQueueEmpty(0);
    loadWeights(0, 16'd1, 16'd1);
    pushResults(0, 16'd14, 16'd32, 16'd50, 16'd68, 4);
    applyStimulus(0, 16'd1, 16'd2, 16'd3, 8'b0000_0111, 3, 0);
    waitDone(0, done_cnt[0] + 1, 200);
    checkQueueEmpty(0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
